// File: rtl/pin_io_bank_if.sv
// ---------------------------------------------------------------
// pin_io_bank_if: core/pad signal bundle for one pin_io_bank; Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

interface pin_io_bank_if #(
  parameter int NUMPINS = 32
);

  logic [NUMPINS-1:0] pad_in;
  logic [NUMPINS-1:0] pad_out;
  logic [NUMPINS-1:0] pad_oe;
  logic [NUMPINS-1:0] pin_out;
  logic [NUMPINS-1:0] pin_dir;
  logic [NUMPINS-1:0] filt_en;
  logic [NUMPINS-1:0] pin_in;
  logic [NUMPINS-1:0] rise;
  logic [NUMPINS-1:0] fall;
  logic [NUMPINS-1:0] chg_flag;
  logic [NUMPINS-1:0] chg_clr;

  modport master (
    output pad_in, pin_out, pin_dir, filt_en, chg_clr,
    input  pad_out, pad_oe, pin_in, rise, fall, chg_flag
  );

  modport slave (
    input  pad_in, pin_out, pin_dir, filt_en, chg_clr,
    output pad_out, pad_oe, pin_in, rise, fall, chg_flag
  );

endinterface

`default_nettype wire

// File: rtl/pin_io_bank.sv
// ---------------------------------------------------------------
// pin_io_bank: pad synchroniser, glitch filter, loopback mux, edge/change flags
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module pin_io_bank #(
  parameter int                 NUMPINS     = 32,
  parameter int                 SYNC_STAGES = 2,
  parameter int                 FILTER_BITS = 4,
  parameter logic [NUMPINS-1:0] INIT        = {NUMPINS{1'b0}}
) (
  input  wire logic     clk_cog,
  input  wire logic     res,
  pin_io_bank_if.slave  io
);

  localparam int                     MAX      = (1 << FILTER_BITS) - 1;
  localparam logic [FILTER_BITS-1:0] CNT_LAST = FILTER_BITS'(MAX - 1);

  generate
    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
      $error("pin_io_bank: SYNC_STAGES must be at least 2");
    end
  endgenerate

  logic [NUMPINS-1:0]     sync_q [SYNC_STAGES];
  logic [NUMPINS-1:0]     sync_d [SYNC_STAGES];
  logic [NUMPINS-1:0]     stable_q, stable_d;
  logic [NUMPINS-1:0]     hist_q, hist_d;
  logic [NUMPINS-1:0]     chg_flag_q, chg_flag_d;
  logic [FILTER_BITS-1:0] cnt_q [NUMPINS];
  logic [FILTER_BITS-1:0] cnt_d [NUMPINS];
  logic [NUMPINS-1:0]     sync_last;
  logic [NUMPINS-1:0]     rise_w, fall_w;

  assign io.pad_out = io.pin_out;
  assign io.pad_oe  = io.pin_dir;
  assign io.pin_in  = (io.pin_dir & io.pin_out) | (~io.pin_dir & stable_q);

  assign sync_last = sync_q[SYNC_STAGES-1];
  assign rise_w    = stable_q & ~hist_q;
  assign fall_w    = ~stable_q & hist_q;

  assign io.rise     = rise_w;
  assign io.fall     = fall_w;
  assign io.chg_flag = chg_flag_q;

  always_comb begin
    sync_d[0] = io.pad_in;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  // Counter only ever advances while the pin disagrees; any agreeing sample or
  // a disabled filter drops it back to zero, so it cannot wrap.
  always_comb begin
    stable_d = stable_q;
    for (int p = 0; p < NUMPINS; p++) begin
      cnt_d[p] = '0;
      if (!io.filt_en[p]) begin
        stable_d[p] = sync_last[p];
      end else if (sync_last[p] != stable_q[p]) begin
        if (cnt_q[p] == CNT_LAST) begin
          stable_d[p] = sync_last[p];
        end else begin
          cnt_d[p] = cnt_q[p] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    hist_d     = stable_q;
    chg_flag_d = (chg_flag_q & ~io.chg_clr) | rise_w | fall_w;
  end

  always_ff @(posedge clk_cog or posedge res) begin
    if (res) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= INIT;
      end
      stable_q   <= INIT;
      hist_q     <= INIT;
      chg_flag_q <= '0;
      for (int p = 0; p < NUMPINS; p++) begin
        cnt_q[p] <= '0;
      end
    end else begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_d[s];
      end
      stable_q   <= stable_d;
      hist_q     <= hist_d;
      chg_flag_q <= chg_flag_d;
      for (int p = 0; p < NUMPINS; p++) begin
        cnt_q[p] <= cnt_d[p];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pin_io_bank.sv
// ---------------------------------------------------------------
// tb_pin_io_bank: directed scenarios plus randomized run against a run-length model
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_pin_io_bank;

  localparam int                 NUMPINS     = 32;
  localparam int                 SYNC_STAGES = 2;
  localparam int                 FILTER_BITS = 4;
  localparam logic [NUMPINS-1:0] INIT        = '0;
  localparam int                 MAX         = (1 << FILTER_BITS) - 1;
  localparam logic [NUMPINS-1:0] ONES        = '1;
  localparam logic [NUMPINS-1:0] ZERO        = '0;

  logic clk_cog = 1'b0;
  logic res     = 1'b1;
  int   checks  = 0;
  int   errors  = 0;

  always #5 clk_cog = ~clk_cog;

  pin_io_bank_if #(.NUMPINS(NUMPINS)) bus ();

  pin_io_bank #(
    .NUMPINS    (NUMPINS),
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_BITS(FILTER_BITS),
    .INIT       (INIT)
  ) dut (
    .clk_cog(clk_cog),
    .res    (res),
    .io     (bus.slave)
  );

  // Reference model: pad samples age through a delay line; a pin's settled level
  // moves once it has seen MAX consecutive disagreeing samples (or at once when unfiltered).
  logic [NUMPINS-1:0] m_line [SYNC_STAGES];
  logic [NUMPINS-1:0] m_stable, m_prev, m_flag;
  logic [NUMPINS-1:0] n_stable, n_flag;
  int                 m_run [NUMPINS];
  int                 n_run [NUMPINS];
  logic [NUMPINS-1:0] m_seen;

  assign m_seen = m_line[SYNC_STAGES-1];

  always_comb begin
    n_stable = m_stable;
    n_flag   = (m_flag & ~bus.chg_clr) | (m_stable ^ m_prev);
    for (int p = 0; p < NUMPINS; p++) begin
      n_run[p] = 0;
      if (!bus.filt_en[p]) begin
        n_stable[p] = m_seen[p];
      end else if (m_seen[p] !== m_stable[p]) begin
        if (m_run[p] + 1 >= MAX) n_stable[p] = m_seen[p];
        else                     n_run[p]    = m_run[p] + 1;
      end
    end
  end

  always_ff @(posedge clk_cog or posedge res) begin
    if (res) begin
      for (int s = 0; s < SYNC_STAGES; s++) m_line[s] <= INIT;
      for (int p = 0; p < NUMPINS; p++) m_run[p] <= 0;
      m_stable <= INIT;
      m_prev   <= INIT;
      m_flag   <= '0;
    end else begin
      m_line[0] <= bus.pad_in;
      for (int s = 1; s < SYNC_STAGES; s++) m_line[s] <= m_line[s-1];
      for (int p = 0; p < NUMPINS; p++) m_run[p] <= n_run[p];
      m_stable <= n_stable;
      m_prev   <= m_stable;
      m_flag   <= n_flag;
    end
  end

  task automatic settle(input logic [NUMPINS-1:0] lvl);
    bus.filt_en = '0;
    bus.pin_dir = '0;
    bus.pin_out = '0;
    bus.chg_clr = '0;
    bus.pad_in  = lvl;
    repeat (6) @(negedge clk_cog);
    bus.chg_clr = '1;
    @(negedge clk_cog);
    bus.chg_clr = '0;
  endtask

  task automatic test_reset;
    bus.pad_in  = ONES;
    bus.filt_en = '0;
    bus.pin_dir = '0;
    bus.pin_out = '0;
    bus.chg_clr = '0;
    res = 1'b1;
    repeat (3) @(negedge clk_cog);
    checks++;
    if (bus.rise !== ZERO || bus.fall !== ZERO) begin
      errors++;
      $display("FAIL reset_edges rise=%h fall=%h required 0", bus.rise, bus.fall);
    end
    checks++;
    if (bus.chg_flag !== ZERO) begin
      errors++;
      $display("FAIL reset_flag got %h required 0", bus.chg_flag);
    end
    checks++;
    if (bus.pin_in !== INIT) begin
      errors++;
      $display("FAIL reset_pin_in got %h required %h", bus.pin_in, INIT);
    end
    res = 1'b0;
    for (int e = 0; e < 5; e++) begin
      @(negedge clk_cog);
      checks++;
      if (bus.rise !== ((e == 2) ? ONES : ZERO)) begin
        errors++;
        $display("FAIL release_rise edge %0d got %h required %h", e, bus.rise, (e == 2) ? ONES : ZERO);
      end
      checks++;
      if (bus.chg_flag !== ((e >= 3) ? ONES : ZERO)) begin
        errors++;
        $display("FAIL release_flag edge %0d got %h required %h", e, bus.chg_flag, (e >= 3) ? ONES : ZERO);
      end
    end
  endtask

  task automatic test_unfiltered;
    settle(ZERO);
    bus.pad_in[3] = 1'b1;
    for (int e = 0; e < 5; e++) begin
      @(negedge clk_cog);
      checks++;
      if (bus.pin_in[3] !== (e >= 2)) begin
        errors++;
        $display("FAIL unfilt_pin_in edge %0d got %b required %b", e, bus.pin_in[3], (e >= 2));
      end
      checks++;
      if (bus.rise !== ((e == 2) ? NUMPINS'(32'h8) : ZERO)) begin
        errors++;
        $display("FAIL unfilt_rise edge %0d got %h", e, bus.rise);
      end
      checks++;
      if (bus.chg_flag[3] !== (e >= 3)) begin
        errors++;
        $display("FAIL unfilt_flag edge %0d got %b required %b", e, bus.chg_flag[3], (e >= 3));
      end
    end
  endtask

  task automatic test_filter;
    settle(ZERO);
    bus.filt_en[5] = 1'b1;
    bus.pad_in[5]  = 1'b1;
    for (int e = 0; e < 30; e++) begin
      @(negedge clk_cog);
      checks++;
      if (bus.rise[5] !== 1'b0 || bus.pin_in[5] !== 1'b0) begin
        errors++;
        $display("FAIL filt14 edge %0d rise=%b pin_in=%b required 0/0", e, bus.rise[5], bus.pin_in[5]);
      end
      if (e == 13) bus.pad_in[5] = 1'b0;
    end
    checks++;
    if (dut.cnt_q[5] !== '0) begin
      errors++;
      $display("FAIL filt14_cnt got %0d required 0", dut.cnt_q[5]);
    end
    bus.pad_in[5] = 1'b1;
    for (int e = 0; e < 30; e++) begin
      @(negedge clk_cog);
      checks++;
      if (bus.rise[5] !== (e == 16)) begin
        errors++;
        $display("FAIL filt15_rise edge %0d got %b required %b", e, bus.rise[5], (e == 16));
      end
      checks++;
      if (bus.pin_in[5] !== (e >= 16)) begin
        errors++;
        $display("FAIL filt15_stable edge %0d got %b required %b", e, bus.pin_in[5], (e >= 16));
      end
      if (e == 14) bus.pad_in[5] = 1'b0;
    end
  endtask

  task automatic test_loopback;
    settle(ZERO);
    bus.pin_dir[7] = 1'b1;
    bus.pin_out[7] = 1'b1;
    #1;
    checks++;
    if (bus.pin_in[7] !== 1'b1 || bus.pad_oe[7] !== 1'b1 || bus.pad_out[7] !== 1'b1) begin
      errors++;
      $display("FAIL loopback_on pin_in=%b oe=%b out=%b required 1/1/1",
               bus.pin_in[7], bus.pad_oe[7], bus.pad_out[7]);
    end
    bus.pin_dir[7] = 1'b0;
    #1;
    checks++;
    if (bus.pin_in[7] !== 1'b0 || bus.pad_oe[7] !== 1'b0 || bus.pad_out[7] !== 1'b1) begin
      errors++;
      $display("FAIL loopback_off pin_in=%b oe=%b out=%b required 0/0/1",
               bus.pin_in[7], bus.pad_oe[7], bus.pad_out[7]);
    end
    bus.pin_out[7] = 1'b0;
  endtask

  task automatic test_flag_race;
    settle(ZERO);
    bus.pad_in[9] = 1'b1;
    repeat (3) @(negedge clk_cog);
    checks++;
    if (bus.rise[9] !== 1'b1) begin
      errors++;
      $display("FAIL race_rise got %b required 1", bus.rise[9]);
    end
    bus.chg_clr[9] = 1'b1;
    @(negedge clk_cog);
    checks++;
    if (bus.chg_flag[9] !== 1'b1) begin
      errors++;
      $display("FAIL race_set_wins got %b required 1", bus.chg_flag[9]);
    end
    @(negedge clk_cog);
    checks++;
    if (bus.chg_flag[9] !== 1'b0) begin
      errors++;
      $display("FAIL race_clear got %b required 0", bus.chg_flag[9]);
    end
    bus.chg_clr[9] = 1'b0;
  endtask

  task automatic test_filter_toggle_reset;
    settle(ZERO);
    bus.filt_en[11] = 1'b1;
    bus.pad_in[11]  = 1'b1;
    repeat (10) @(negedge clk_cog);
    checks++;
    if (dut.cnt_q[11] !== FILTER_BITS'(8)) begin
      errors++;
      $display("FAIL toggle_cnt got %0d required 8", dut.cnt_q[11]);
    end
    bus.filt_en[11] = 1'b0;
    @(negedge clk_cog);
    checks++;
    if (bus.pin_in[11] !== 1'b1 || bus.rise[11] !== 1'b1 || dut.cnt_q[11] !== '0) begin
      errors++;
      $display("FAIL toggle_follow pin_in=%b rise=%b cnt=%0d required 1/1/0",
               bus.pin_in[11], bus.rise[11], dut.cnt_q[11]);
    end
    bus.filt_en[12] = 1'b1;
    bus.pad_in[12]  = 1'b1;
    repeat (12) @(negedge clk_cog);
    checks++;
    if (dut.cnt_q[12] !== FILTER_BITS'(10)) begin
      errors++;
      $display("FAIL midreset_cnt_pre got %0d required 10", dut.cnt_q[12]);
    end
    res = 1'b1;
    #1;
    checks++;
    if (bus.pin_in !== INIT || dut.cnt_q[12] !== '0) begin
      errors++;
      $display("FAIL midreset_state pin_in=%h cnt=%0d required %h/0", bus.pin_in, dut.cnt_q[12], INIT);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_cog);
      checks++;
      if (bus.rise !== ZERO || bus.fall !== ZERO || bus.chg_flag !== ZERO) begin
        errors++;
        $display("FAIL midreset_pulses rise=%h fall=%h flag=%h required 0",
                 bus.rise, bus.fall, bus.chg_flag);
      end
    end
    res = 1'b0;
  endtask

  task automatic test_random;
    logic [NUMPINS-1:0] exp_pin_in;
    for (int c = 0; c < 700; c++) begin
      @(negedge clk_cog);
      exp_pin_in = (bus.pin_dir & bus.pin_out) | (~bus.pin_dir & m_stable);
      checks++;
      if (bus.pin_in !== exp_pin_in) begin
        errors++;
        $display("FAIL rnd_pin_in cyc %0d got %h required %h", c, bus.pin_in, exp_pin_in);
      end
      checks++;
      if (bus.rise !== (m_stable & ~m_prev) || bus.fall !== (~m_stable & m_prev)) begin
        errors++;
        $display("FAIL rnd_edges cyc %0d rise=%h fall=%h required %h/%h", c, bus.rise, bus.fall,
                 m_stable & ~m_prev, ~m_stable & m_prev);
      end
      checks++;
      if (bus.chg_flag !== m_flag) begin
        errors++;
        $display("FAIL rnd_flag cyc %0d got %h required %h", c, bus.chg_flag, m_flag);
      end
      checks++;
      if (bus.pad_out !== bus.pin_out || bus.pad_oe !== bus.pin_dir) begin
        errors++;
        $display("FAIL rnd_pad cyc %0d out=%h oe=%h required %h/%h", c, bus.pad_out, bus.pad_oe,
                 bus.pin_out, bus.pin_dir);
      end
      if (c == 350) res = 1'b1;
      if (c == 353) res = 1'b0;
      if (c % 60 == 0) bus.filt_en = $urandom;
      if (c < 350) bus.pad_in = bus.pad_in ^ ($urandom & $urandom & $urandom & $urandom & $urandom);
      else         bus.pad_in = bus.pad_in ^ ($urandom & $urandom & $urandom);
      bus.pin_dir = $urandom & $urandom;
      bus.pin_out = $urandom;
      bus.chg_clr = $urandom & $urandom;
    end
  endtask

  initial begin
    test_reset();
    test_unfiltered();
    test_filter();
    test_loopback();
    test_flag_race();
    test_filter_toggle_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pin_io_bank.md
# pin_io_bank

Parametrised pin I/O front end between board pads and the `dig` core. It generalises the per-pin tri-state assignment done in each board top level. Each pin gets a multi-stage input synchroniser and an optional per-pin glitch filter. It also provides output-loopback muxing, rise/fall event pulses and sticky change flags. Board top levels instantiate one bank and connect `pad_out`/`pad_oe` to their `inout` pins.

## Interface
- `NUMPINS`, 32, number of pins in the bank
- `SYNC_STAGES`, 2, synchroniser flops per pin; legal range ≥ 2
- `FILTER_BITS`, 4, filter counter width; acceptance threshold MAX = 2^FILTER_BITS − 1 consecutive samples
- `INIT`, {NUMPINS{1'b0}}, reset value of synchroniser, filtered-state and edge-history flops
- `clk_cog  in  1  bank clock; all flops on rising edge`
- `res  in  1  reset, asynchronous, active-high`
- `pad_in  in  NUMPINS  raw pad levels, asynchronous to clk_cog`
- `pad_out  out  NUMPINS  pad drive value`
- `pad_oe  out  NUMPINS  pad drive enable (1 = drive)`
- `pin_out  in  NUMPINS  core output values`
- `pin_dir  in  NUMPINS  core direction (1 = output)`
- `filt_en  in  NUMPINS  per-pin glitch filter enable`
- `pin_in  out  NUMPINS  input bus to core`
- `rise  out  NUMPINS  one-cycle pulse on filtered 0→1`
- `fall  out  NUMPINS  one-cycle pulse on filtered 1→0`
- `chg_flag  out  NUMPINS  sticky change flag`
- `chg_clr  in  NUMPINS  per-pin flag clear, sampled on clk_cog`

## Operation
- Output path is combinational with no added latency: `pad_out = pin_out` and `pad_oe = pin_dir`.
- Synchroniser: `pad_in[i]` passes through SYNC_STAGES flops. The last stage is `sync[i]`.
- Filter state per pin: `stable[i]` (1 bit) and `cnt[i]` (FILTER_BITS bits).
- When `filt_en[i]=0`: `stable <= sync` and `cnt <= 0` every cycle.
- When `filt_en[i]=1` and `sync == stable`: `cnt <= 0`.
- When `filt_en[i]=1` and `sync != stable`:
  - if `cnt == MAX−1`: `stable <= sync` and `cnt <= 0`;
  - otherwise: `cnt <= cnt + 1`.
- Counter never wraps. A glitch shorter than MAX samples leaves `stable` unchanged and clears `cnt` on the first agreeing sample.
- Deasserting `filt_en` mid-count clears `cnt`, and `stable` takes `sync` on that same edge.
- Asserting `filt_en` starts counting from `cnt=0`.
- Input mux: `pin_in[i] = pin_dir[i] ? pin_out[i] : stable[i]`. This is combinational, so the core sees its own output with zero latency.
- Edge history: `stable_d <= stable`.
  - `rise = stable & ~stable_d`
  - `fall = ~stable & stable_d`
  - Edges are derived from pad state and reported regardless of `pin_dir`.
- Change flag: `chg_flag[i] <= (chg_flag[i] & ~chg_clr[i]) | rise[i] | fall[i]`. A simultaneous set and clear leaves the flag set.
- Pins are fully independent; no cross-pin logic.

## Timing
- Reset (`res=1`, async):
  - synchroniser, `stable` and `stable_d` go to INIT;
  - `cnt` = 0;
  - `chg_flag` = 0;
  - `rise`/`fall` = 0, because `stable == stable_d`.
  - `pad_out`, `pad_oe` and `pin_in` with `pin_dir=1` follow their inputs even during reset. `pin_in` with `pin_dir=0` = INIT.
- Release of `res` generates no edge pulses, whatever the pad level, until the pad value propagates.
- Edge numbering: pad changes before edge 0.
  - `sync` changes after edge S−1 (S = SYNC_STAGES).
  - Unfiltered: `stable` and the `rise`/`fall` pulse appear after edge S. `chg_flag` sets after edge S+1.
  - Filtered: `stable` changes after edge S−1+MAX, provided the pad held its level throughout. With defaults that is edge 16.
- `rise`/`fall` are high for exactly one cycle per filtered transition.
- `res` asserted mid-filter-count aborts the count; `stable` returns to INIT.

## Test plan
- **Reset:** INIT=0 and `pad_in`=all-ones during reset, then release `res`. Required: `rise`/`fall`=0 during reset. Exactly one `rise` per pin appears after edge 2, and `chg_flag`=all-ones from edge 3.
- **Unfiltered latency:** `filt_en[3]=0`, `pad_in[3]` 0→1 before edge 0. Required: `pin_in[3]`=1 and `rise[3]`=1 after edge 2 only. `chg_flag[3]`=1 after edge 3.
- **Filter threshold:** `filt_en[5]=1`, FILTER_BITS=4.
  - A 14-cycle high pulse produces no change in `stable`, no `rise`, and `cnt` returns to 0.
  - A 15-cycle pulse produces `rise[5]` after edge 16.
- **Loopback:** `pin_dir[7]=1`, `pin_out[7]=1`, `pad_in[7]=0`. Required: `pin_in[7]=1` in the same cycle, `pad_oe[7]=1`, `pad_out[7]=1`. Set `pin_dir[7]=0`: `pin_in[7]=0` immediately.
- **Flag clear race:** assert `chg_clr[9]` in the cycle `rise[9]` is high. Required: `chg_flag[9]` remains 1. Clear alone on the next cycle gives 0.
- **Filter toggle and reset mid-count:** drop `filt_en` at `cnt=8`. Required: `stable` follows `sync` on the next edge. Assert `res` at `cnt=10`. Required: `stable`=INIT, `cnt`=0, no pulses.
